// File: rtl/pcihellocore_switch_edge.sv
// rtl/pcihellocore_switch_edge.sv - synchronised, debounced switch input port with edge capture and irq
// Avalon-MM slave: data / irqmask / reserved / edgecapture (write-1-to-clear).
`timescale 1ns/1ps

module pcihellocore_switch_edge #(
  parameter int WIDTH           = 32,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 0,
  parameter int EDGE_TYPE       = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int CW = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] filt_q, filt_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [WIDTH-1:0] rise, fall, edge_ev, clr, wd;
  logic [31:0]      readdata_q, readdata_d;
  logic             wr;
  logic             unused_wd;

  assign sync      = sync_q[SYNC_STAGES-1];
  assign wr        = chipselect & ~write_n;
  assign wd        = writedata[WIDTH-1:0];
  assign unused_wd = ^writedata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
    end
  end

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      assign filt_d = sync;
    end else begin : g_debounce
      logic [WIDTH-1:0][CW-1:0] cnt_q, cnt_d;

      // Counter runs only while sync disagrees with filt; any agreement restarts it.
      always_comb begin
        filt_d = filt_q;
        cnt_d  = cnt_q;
        for (int i = 0; i < WIDTH; i++) begin
          if (sync[i] == filt_q[i]) begin
            cnt_d[i] = '0;
          end else if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
            filt_d[i] = sync[i];
            cnt_d[i]  = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
          end
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end
    end
  endgenerate

  assign rise = filt_d & ~filt_q;
  assign fall = ~filt_d & filt_q;

  always_comb begin
    case (EDGE_TYPE)
      0:       edge_ev = rise;
      1:       edge_ev = fall;
      default: edge_ev = rise | fall;
    endcase
  end

  // A new edge overrides a clear landing on the same cycle.
  always_comb begin
    mask_d = mask_q;
    clr    = '0;
    if (wr && address == 2'd1) mask_d = wd;
    if (wr && address == 2'd3) clr = wd;
    cap_d = (cap_q & ~clr) | edge_ev;
  end

  always_comb begin
    readdata_d = '0;
    case (address)
      2'd0:    readdata_d[WIDTH-1:0] = filt_q;
      2'd1:    readdata_d[WIDTH-1:0] = mask_q;
      2'd3:    readdata_d[WIDTH-1:0] = cap_q;
      default: readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt_q     <= '0;
      mask_q     <= '0;
      cap_q      <= '0;
      readdata_q <= '0;
    end else begin
      filt_q     <= filt_d;
      mask_q     <= mask_d;
      cap_q      <= cap_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(cap_q & mask_q);

endmodule

// File: tb/tb_pcihellocore_switch_edge.sv
// tb/tb_pcihellocore_switch_edge.sv - randomized and directed bench for pcihellocore_switch_edge
// Three configurations share the bus and inputs; each is compared to a sample-history model.
`timescale 1ns/1ps

module tb_pcihellocore_switch_edge;
  localparam int W = 8;
  localparam int NI = 3;
  localparam int HL = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    address;
  logic          chipselect, write_n;
  logic [31:0]   writedata;
  logic [W-1:0]  in_port;
  logic [31:0]   rd [NI];
  logic          irq [NI];

  int n_checks = 0;
  int n_fail = 0;

  int ps [NI];
  int pd [NI];
  int pe [NI];

  logic [W-1:0]  hist [NI][HL];
  logic [W-1:0]  m_filt [NI];
  logic [W-1:0]  m_mask [NI];
  logic [W-1:0]  m_cap [NI];
  logic [31:0]   m_rd [NI];

  always #5 clk = ~clk;

  pcihellocore_switch_edge #(.WIDTH(W), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(0)) u_a (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_port), .readdata(rd[0]), .irq(irq[0]));
  pcihellocore_switch_edge #(.WIDTH(W), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(2)) u_b (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_port), .readdata(rd[1]), .irq(irq[1]));
  pcihellocore_switch_edge #(.WIDTH(W), .SYNC_STAGES(3), .DEBOUNCE_CYCLES(1), .EDGE_TYPE(1)) u_c (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_port), .readdata(rd[2]), .irq(irq[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      for (int j = 0; j < HL; j++) hist[k][j] = '0;
      m_filt[k] = '0;
      m_mask[k] = '0;
      m_cap[k]  = '0;
      m_rd[k]   = '0;
    end
  endtask

  // Filter rule: a bit flips when the last D synchronised samples all disagree with it.
  task automatic model_edge();
    logic [W-1:0] nf, ev, clr, wd;
    bit wr, all_diff;
    wr = chipselect && !write_n;
    wd = writedata[W-1:0];
    for (int k = 0; k < NI; k++) begin
      for (int j = HL - 1; j > 0; j--) hist[k][j] = hist[k][j-1];
      hist[k][0] = in_port;
      if (pd[k] == 0) begin
        nf = hist[k][ps[k]];
      end else begin
        for (int b = 0; b < W; b++) begin
          all_diff = 1'b1;
          for (int j = ps[k]; j < ps[k] + pd[k]; j++)
            if (hist[k][j][b] == m_filt[k][b]) all_diff = 1'b0;
          nf[b] = all_diff ? ~m_filt[k][b] : m_filt[k][b];
        end
      end
      case (pe[k])
        0:       ev = nf & ~m_filt[k];
        1:       ev = ~nf & m_filt[k];
        default: ev = nf ^ m_filt[k];
      endcase
      case (address)
        2'd0:    m_rd[k] = 32'(m_filt[k]);
        2'd1:    m_rd[k] = 32'(m_mask[k]);
        2'd3:    m_rd[k] = 32'(m_cap[k]);
        default: m_rd[k] = 32'd0;
      endcase
      clr = (wr && address == 2'd3) ? wd : '0;
      if (wr && address == 2'd1) m_mask[k] = wd;
      m_cap[k]  = (m_cap[k] & ~clr) | ev;
      m_filt[k] = nf;
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < NI; k++) begin
      check($sformatf("%s_rd%0d", tag, k), rd[k], m_rd[k]);
      check($sformatf("%s_irq%0d", tag, k), 32'(irq[k]), 32'(|(m_cap[k] & m_mask[k])));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all("mdl");
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
    step();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_rd(input logic [1:0] a);
    address = a;
    step();
  endtask

  task automatic do_reset(input bit short_pulse);
    if (short_pulse) begin
      @(negedge clk);
      #1 reset = 1'b1;
      model_reset();
      #1;
      check_all("rst_short");
      #1 reset = 1'b0;
    end else begin
      reset = 1'b1;
      model_reset();
      #1;
      check_all("rst_long");
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
    end
  endtask

  initial begin
    int k;
    ps = '{2, 2, 3};
    pd = '{0, 4, 1};
    pe = '{0, 2, 1};
    reset = 1'b1; address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
    writedata = '0; in_port = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_irq_a", 32'(irq[0]), 32'd0);
    reset = 1'b0;

    for (int a = 0; a < 4; a++) begin
      bus_rd(2'(a));
      check($sformatf("idle_rd_a%0d", a), rd[0], 32'd0);
      check($sformatf("idle_rd_b%0d", a), rd[1], 32'd0);
    end

    address = 2'd0;
    in_port = 8'hA5;
    k = 0;
    do begin step(); k++; end while (rd[0] != 32'hA5 && k < 12);
    check("lat_rd_a", 32'(k), 32'd4);
    bus_rd(2'd3);
    check("lat_cap_a", rd[0], 32'hA5);

    in_port = '0; steps(8);
    bus_wr(2'd3, 32'hFFFF_FFFF);
    address = 2'd0;
    in_port = 8'h01; steps(3);
    in_port = 8'h00; steps(8);
    check("deb_glitch_data", rd[1], 32'd0);
    bus_rd(2'd3);
    check("deb_glitch_cap", rd[1], 32'd0);
    address = 2'd0;
    in_port = 8'h01;
    k = 0;
    do begin step(); k++; end while (rd[1][0] != 1'b1 && k < 20);
    check("deb_lat_b", 32'(k), 32'd7);
    bus_rd(2'd3);
    check("deb_cap_b", rd[1], 32'h01);

    in_port = '0; steps(8);
    bus_wr(2'd3, 32'hFF);
    in_port = 8'h03; steps(5);
    bus_wr(2'd1, 32'h01);
    check("irq_set_a", 32'(irq[0]), 32'd1);
    bus_wr(2'd3, 32'h01);
    check("irq_clr_a", 32'(irq[0]), 32'd0);
    bus_rd(2'd3);
    check("cap_after_clr_a", rd[0], 32'h02);
    bus_wr(2'd1, 32'hFFFF_FF02);
    check("irq_mask2_a", 32'(irq[0]), 32'd1);

    in_port = '0; steps(6);
    bus_wr(2'd3, 32'hFF);
    in_port = 8'h08; steps(2);
    bus_wr(2'd3, 32'h08);
    bus_rd(2'd3);
    check("simul_set_clr_a", rd[0] & 32'h08, 32'h08);

    in_port = 8'h02; steps(8);
    bus_wr(2'd3, 32'hFF);
    in_port = 8'h00; steps(8);
    bus_rd(2'd3);
    check("fall_cap_b", rd[1], 32'h02);

    in_port = 8'h01; steps(4);
    do_reset(1'b0);
    check("rst_mid_irq_b", 32'(irq[1]), 32'd0);
    for (int a = 0; a < 4; a++) begin
      bus_rd(2'(a));
      check($sformatf("rst_mid_rd_b%0d", a), rd[1], 32'd0);
    end

    do_reset(1'b1);
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 7) == 0) in_port = W'($urandom);
      address    = 2'($urandom_range(0, 3));
      chipselect = 1'($urandom_range(0, 1));
      write_n    = ($urandom_range(0, 3) != 0);
      writedata  = $urandom;
      if ($urandom_range(0, 199) == 0) do_reset(1'($urandom_range(0, 1)));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

endmodule
